// File: rtl/rr_handshake_arbiter.sv
// Round-robin valid/ready arbiter with burst locking and a single registered output stage.
// Each grant may hold a requester for up to MAX_BURST consecutive beats.
module rr_handshake_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    data_in,
  input  logic [NUM_IN-1:0]                    data_in_valid,
  output logic [NUM_IN-1:0]                    data_in_ready,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [$clog2(NUM_IN)-1:0]            data_out_src,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int unsigned SRC_W = $clog2(NUM_IN);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0] lock_idx, lock_idx_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_act;
  logic             load_en;
  logic             xfer;

  function automatic logic [SRC_W-1:0] inc_idx(input logic [SRC_W-1:0] idx);
    return (32'(idx) == NUM_IN - 1) ? '0 : SRC_W'(32'(idx) + 1);
  endfunction

  assign load_en = !data_out_valid || data_out_ready;

  // Grant depends only on state, pointer and input valids, never on any ready.
  always_comb begin : grant_sel
    int unsigned cand;
    grant_act = 1'b0;
    grant_idx = lock_idx;
    cand      = 0;
    if (state == BURST) begin
      grant_act = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cand = 32'(rr_ptr) + i;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        if (!grant_act && data_in_valid[SRC_W'(cand)]) begin
          grant_act = 1'b1;
          grant_idx = SRC_W'(cand);
        end
      end
    end
  end

  always_comb begin
    data_in_ready = '0;
    if (grant_act && load_en && !rst) data_in_ready[grant_idx] = 1'b1;
  end

  assign xfer = grant_act && load_en && data_in_valid[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Burst tracking: a lock ends on MAX_BURST beats or when the owner drops valid while unstalled.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = inc_idx(grant_idx);
          end else begin
            state_nxt    = BURST;
            lock_idx_nxt = grant_idx;
            beat_cnt_nxt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (load_en) begin
          if (!data_in_valid[lock_idx]) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = inc_idx(lock_idx);
            beat_cnt_nxt = '0;
          end else if (32'(beat_cnt) + 1 >= MAX_BURST) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = inc_idx(lock_idx);
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_src   <= '0;
      data_out_valid <= 1'b0;
    end else if (load_en) begin
      data_out_valid <= xfer;
      if (xfer) begin
        data_out     <= data_in[grant_idx];
        data_out_src <= grant_idx;
      end
    end
  end

endmodule
